uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_arbiter_rr.sv | 32 +++
 rtl/uart_tx_arbiter.sv | 92 +++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and sizing for the UART transmit arbiter.
// Owns requester count, index width and FSM encoding.
package uart_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = $clog2(NUM_REQ);

    typedef logic [IDX_W-1:0] req_idx_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_START,
        S_WAIT_DONE
    } tx_state_t;

    function automatic logic [NUM_REQ-1:0] idx_onehot(input req_idx_t i);
        return NUM_REQ'(1) << i;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin pick: first masked request
// found searching upward from ptr, wrapping modulo NUM_REQ.
module rr_arbiter
    import uart_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  req_idx_t           ptr,
    input  logic [NUM_REQ-1:0] mask,
    output logic [NUM_REQ-1:0] gnt,
    output req_idx_t           idx,
    output logic               any
);

    req_idx_t cand;

    // Scan from farthest to nearest so the nearest hit wins.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ptr + req_idx_t'(k);
            if (req[cand] && mask[cand]) begin
                gnt = idx_onehot(cand);
                idx = cand;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte sources,
// holding ownership across multi-byte messages.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic                 tx_busy,
    output logic                 tx_data_valid,
    output logic [7:0]           tx_p_data,
    output req_idx_t             grant_id,
    output logic                 active
);

    tx_state_t          state;
    tx_state_t          state_nx;
    req_idx_t           rr_ptr;
    logic               lock;
    logic               last_q;
    logic [NUM_REQ-1:0] lock_mask;
    logic [NUM_REQ-1:0] gnt;
    req_idx_t           gidx;
    logic               gany;
    logic               accept;
    logic               done;

    assign lock_mask = lock ? idx_onehot(grant_id) : '1;

    rr_arbiter u_rr (
        .req  (req_valid),
        .ptr  (rr_ptr),
        .mask (lock_mask),
        .gnt  (gnt),
        .idx  (gidx),
        .any  (gany)
    );

    // Reset low also blocks the strobe so nothing is consumed mid-reset.
    assign accept = (state == S_IDLE) && rst && !tx_busy && gany;
    assign req_ready = accept ? gnt : '0;
    assign done = (state == S_WAIT_DONE) && !tx_busy;

    // Next-state: accept, launch, then track the busy pulse.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:       if (accept) state_nx = S_SEND;
            S_SEND:       state_nx = S_WAIT_START;
            S_WAIT_START: if (tx_busy) state_nx = S_WAIT_DONE;
            S_WAIT_DONE:  if (!tx_busy) state_nx = S_IDLE;
            default:      state_nx = S_IDLE;
        endcase
    end

    // State, registered outputs, latched byte and lock/pointer upkeep.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= S_IDLE;
            rr_ptr        <= '0;
            lock          <= 1'b0;
            last_q        <= 1'b0;
            tx_data_valid <= 1'b0;
            tx_p_data     <= 8'h00;
            grant_id      <= '0;
            active        <= 1'b0;
        end else begin
            state         <= state_nx;
            tx_data_valid <= accept;
            active        <= (state_nx != S_IDLE);
            if (accept) begin
                grant_id  <= gidx;
                tx_p_data <= req_data[int'(gidx)*8 +: 8];
                last_q    <= req_last[gidx];
            end
            if (done) begin
                if (last_q) begin
                    rr_ptr <= grant_id + 1'b1;
                    lock   <= 1'b0;
                end else begin
                    lock   <= 1'b1;
                end
            end
        end
    end

endmodule
